// File: rtl/pc_fetch_unit.sv
// Multi-cycle instruction fetch stage: owns PC and IR, handshakes with decode via Start/Done/Ready.
// Optional macro PERF_COUNT_EN builds the retired-instruction and taken-branch counters.
//
// state | meaning
// IDLE  | waiting for Start
// FETCH | MemRead asserted, MemAddr = PC
// LATCH | memory data valid, IR captured at exit edge
// READY | IR valid, waiting for Done
module pc_fetch_unit #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             Done,
  input  logic             Branch,
  input  logic             Perform,
  input  logic [WIDTH-1:0] MemData,
  output logic             MemRead,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] IR,
  output logic [3:0]       Op,
  output logic [WIDTH-1:0] signE,
  output logic [WIDTH-1:0] upper,
  output logic             Ready,
  output logic [WIDTH-1:0] RetireCnt,
  output logic [WIDTH-1:0] TakenCnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    READY = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             done_acc;
  logic             taken;

  assign taken = Branch & Perform;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    done_acc = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) state_d = FETCH;
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        ir_d    = MemData;
        state_d = READY;
      end
      READY: begin
        if (Done) begin
          done_acc = 1'b1;
          pc_d     = taken ? (pc_q + signE) : (pc_q + WIDTH'(1));
          state_d  = Start ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode fields are purely combinational from IR so they track IR loads exactly.
  assign PC      = pc_q;
  assign IR      = ir_q;
  assign MemAddr = pc_q;
  assign MemRead = (state_q == FETCH);
  assign Ready   = (state_q == READY);
  assign Op      = ir_q[3:0];
  assign signE   = WIDTH'($signed(ir_q[15:8]));
  assign upper   = WIDTH'({ir_q[15:8], 8'h00});

`ifdef PERF_COUNT_EN
  logic [WIDTH-1:0] retire_q, retire_d;
  logic [WIDTH-1:0] taken_q, taken_d;

  always_comb begin
    retire_d = retire_q;
    taken_d  = taken_q;
    if (done_acc) begin
      retire_d = retire_q + WIDTH'(1);
      if (taken) taken_d = taken_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      retire_q <= '0;
      taken_q  <= '0;
    end else begin
      retire_q <= retire_d;
      taken_q  <= taken_d;
    end
  end

  assign RetireCnt = retire_q;
  assign TakenCnt  = taken_q;
`else
  assign RetireCnt = '0;
  assign TakenCnt  = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit: fetch timing, decode fields, branches, wrap, back-to-back, resets.
// Counter expectations follow PERF_COUNT_EN when it is defined for the bench build.
module tb_pc_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic        Start, Done, Branch, Perform;
  logic [15:0] MemData;
  logic        MemRead;
  logic [15:0] MemAddr, PC, IR, signE, upper, RetireCnt, TakenCnt;
  logic [3:0]  Op;
  logic        Ready;

  logic [15:0] mem [0:65535];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_retire = 0;
  int exp_taken  = 0;

`ifdef PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  pc_fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .Done(Done), .Branch(Branch),
    .Perform(Perform), .MemData(MemData), .MemRead(MemRead), .MemAddr(MemAddr),
    .PC(PC), .IR(IR), .Op(Op), .signE(signE), .upper(upper), .Ready(Ready),
    .RetireCnt(RetireCnt), .TakenCnt(TakenCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous-read memory: data valid the cycle after MemRead.
  always @(posedge CLK) if (MemRead) MemData <= mem[MemAddr];

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b0; Start = 1'b1; Done = 1'b0; Branch = 1'b0; Perform = 1'b0;
    step();
    n_tests++; if (PC !== 16'h0000) begin n_fail++; $display("FAIL reset_pc got %h want 0000", PC); end
    n_tests++; if (IR !== 16'h0000) begin n_fail++; $display("FAIL reset_ir got %h want 0000", IR); end
    n_tests++; if (Ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", Ready); end
    n_tests++; if (MemRead !== 1'b0) begin n_fail++; $display("FAIL reset_memread got %b want 0", MemRead); end
    n_tests++; if (RetireCnt !== 16'h0 || TakenCnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h/%h want 0000/0000", RetireCnt, TakenCnt); end
    RESET = 1'b1; Start = 1'b0;
    step();
    n_tests++; if (MemRead !== 1'b0 || Ready !== 1'b0) begin n_fail++; $display("FAIL reset_nofetch got memread=%b ready=%b want 0/0", MemRead, Ready); end
  endtask

  task automatic test_sequential();
    Start = 1'b1;
    step();
    Start = 1'b0;
    n_tests++; if (MemRead !== 1'b1) begin n_fail++; $display("FAIL seq_memread got %b want 1", MemRead); end
    n_tests++; if (MemAddr !== 16'h0000) begin n_fail++; $display("FAIL seq_memaddr got %h want 0000", MemAddr); end
    step();
    n_tests++; if (MemRead !== 1'b0 || Ready !== 1'b0) begin n_fail++; $display("FAIL seq_latch got memread=%b ready=%b want 0/0", MemRead, Ready); end
    step();
    n_tests++; if (Ready !== 1'b1) begin n_fail++; $display("FAIL seq_ready got %b want 1", Ready); end
    n_tests++; if (IR !== 16'h0010) begin n_fail++; $display("FAIL seq_ir got %h want 0010", IR); end
    n_tests++; if (Op !== 4'h0 || signE !== 16'h0000 || upper !== 16'h0000) begin n_fail++; $display("FAIL seq_decode got op=%h signE=%h upper=%h want 0/0000/0000", Op, signE, upper); end
    Done = 1'b1; Branch = 1'b0;
    step();
    Done = 1'b0;
    exp_retire++;
    n_tests++; if (PC !== 16'h0001) begin n_fail++; $display("FAIL seq_pc got %h want 0001", PC); end
    n_tests++; if (Ready !== 1'b0 || MemRead !== 1'b0) begin n_fail++; $display("FAIL seq_idle got ready=%b memread=%b want 0/0", Ready, MemRead); end
  endtask

  task automatic test_branch_taken();
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    step();
    n_tests++; if (IR !== 16'hFE07) begin n_fail++; $display("FAIL br_ir got %h want FE07", IR); end
    n_tests++; if (Op !== 4'h7) begin n_fail++; $display("FAIL br_op got %h want 7", Op); end
    n_tests++; if (signE !== 16'hFFFE) begin n_fail++; $display("FAIL br_signE got %h want FFFE", signE); end
    n_tests++; if (upper !== 16'hFE00) begin n_fail++; $display("FAIL br_upper got %h want FE00", upper); end
    step();
    n_tests++; if (Ready !== 1'b1 || PC !== 16'h0001) begin n_fail++; $display("FAIL br_hold got ready=%b pc=%h want 1/0001", Ready, PC); end
    Done = 1'b1; Branch = 1'b1; Perform = 1'b1;
    step();
    Done = 1'b0; Branch = 1'b0; Perform = 1'b0;
    exp_retire++; exp_taken++;
    n_tests++; if (PC !== 16'hFFFF) begin n_fail++; $display("FAIL br_taken_pc got %h want FFFF", PC); end
    n_tests++; if (RetireCnt !== (PERF ? 16'(exp_retire) : 16'h0)) begin n_fail++; $display("FAIL br_retire got %h want %h", RetireCnt, PERF ? 16'(exp_retire) : 16'h0); end
    n_tests++; if (TakenCnt !== (PERF ? 16'(exp_taken) : 16'h0)) begin n_fail++; $display("FAIL br_taken_cnt got %h want %h", TakenCnt, PERF ? 16'(exp_taken) : 16'h0); end
  endtask

  // Fetch at FFFF, then Done+Start wraps PC to 0000 and starts the next fetch immediately.
  task automatic test_wrap_back_to_back();
    Start = 1'b1;
    step();
    Start = 1'b0;
    n_tests++; if (MemAddr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_addr got %h want FFFF", MemAddr); end
    step();
    step();
    n_tests++; if (IR !== 16'h1234) begin n_fail++; $display("FAIL wrap_ir got %h want 1234", IR); end
    Done = 1'b1; Start = 1'b1; Branch = 1'b0; Perform = 1'b1;
    step();
    Done = 1'b0; Start = 1'b0; Perform = 1'b0;
    exp_retire++;
    n_tests++; if (PC !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc got %h want 0000", PC); end
    n_tests++; if (MemRead !== 1'b1 || MemAddr !== 16'h0000 || Ready !== 1'b0) begin n_fail++; $display("FAIL b2b_fetch got memread=%b addr=%h ready=%b want 1/0000/0", MemRead, MemAddr, Ready); end
    step();
    Start = 1'b1; Done = 1'b1; Branch = 1'b1; Perform = 1'b1;
    step();
    Start = 1'b0; Done = 1'b0; Branch = 1'b0; Perform = 1'b0;
    n_tests++; if (Ready !== 1'b1 || IR !== 16'h0010 || PC !== 16'h0000) begin n_fail++; $display("FAIL latch_ignore got ready=%b ir=%h pc=%h want 1/0010/0000", Ready, IR, PC); end
    step();
    n_tests++; if (Ready !== 1'b1 || MemRead !== 1'b0) begin n_fail++; $display("FAIL ready_hold got ready=%b memread=%b want 1/0", Ready, MemRead); end
    Done = 1'b1; Start = 1'b1;
    step();
    Done = 1'b0; Start = 1'b0;
    exp_retire++;
    n_tests++; if (MemRead !== 1'b1 || MemAddr !== 16'h0001 || PC !== 16'h0001) begin n_fail++; $display("FAIL b2b2_fetch got memread=%b addr=%h pc=%h want 1/0001/0001", MemRead, MemAddr, PC); end
    step();
    step();
    n_tests++; if (Ready !== 1'b1 || IR !== 16'hFE07) begin n_fail++; $display("FAIL b2b2_ready got ready=%b ir=%h want 1/FE07", Ready, IR); end
    Done = 1'b1; Branch = 1'b1; Perform = 1'b0;
    step();
    Done = 1'b0; Branch = 1'b0;
    exp_retire++;
    n_tests++; if (PC !== 16'h0002) begin n_fail++; $display("FAIL br_nottaken_pc got %h want 0002", PC); end
    n_tests++; if (RetireCnt !== (PERF ? 16'(exp_retire) : 16'h0)) begin n_fail++; $display("FAIL nt_retire got %h want %h", RetireCnt, PERF ? 16'(exp_retire) : 16'h0); end
    n_tests++; if (TakenCnt !== (PERF ? 16'(exp_taken) : 16'h0)) begin n_fail++; $display("FAIL nt_taken_cnt got %h want %h", TakenCnt, PERF ? 16'(exp_taken) : 16'h0); end
  endtask

  task automatic test_reset_midfetch();
    Start = 1'b1;
    step();
    Start = 1'b0;
    n_tests++; if (MemAddr !== 16'h0002) begin n_fail++; $display("FAIL mid_addr got %h want 0002", MemAddr); end
    step();
    RESET = 1'b0;
    step();
    n_tests++; if (IR !== 16'h0000) begin n_fail++; $display("FAIL mid_ir got %h want 0000", IR); end
    n_tests++; if (PC !== 16'h0000) begin n_fail++; $display("FAIL mid_pc got %h want 0000", PC); end
    n_tests++; if (Ready !== 1'b0 || MemRead !== 1'b0) begin n_fail++; $display("FAIL mid_ctrl got ready=%b memread=%b want 0/0", Ready, MemRead); end
    n_tests++; if (RetireCnt !== 16'h0 || TakenCnt !== 16'h0) begin n_fail++; $display("FAIL mid_cnt got %h/%h want 0000/0000", RetireCnt, TakenCnt); end
    RESET = 1'b1;
    step();
    n_tests++; if (Ready !== 1'b0 || MemRead !== 1'b0 || IR !== 16'h0000) begin n_fail++; $display("FAIL mid_idle got ready=%b memread=%b ir=%h want 0/0/0000", Ready, MemRead, IR); end
  endtask

  initial begin
    RESET = 1'b0; Start = 1'b0; Done = 1'b0; Branch = 1'b0; Perform = 1'b0;
    MemData = 16'h0000;
    mem[16'h0000] = 16'h0010;
    mem[16'h0001] = 16'hFE07;
    mem[16'h0002] = 16'hABCD;
    mem[16'hFFFF] = 16'h1234;
    step();
    test_reset();
    test_sequential();
    test_branch_taken();
    test_wrap_back_to_back();
    test_reset_midfetch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
